// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: funct3 encodings,
// FSM states and byte-lane geometry.
package lsu_pkg;

  localparam int XLEN_C    = 32;
  localparam int BYTE_W    = 8;
  localparam int HALF_W    = 16;
  localparam int NUM_LANES = XLEN_C / BYTE_W;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_f3_e;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_f3_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    HOLD = 2'd2
  } lsu_state_e;

  function automatic logic f3_legal(input logic store, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (store) begin
      ok = (f3 == SB) || (f3 == SH) || (f3 == SW);
    end else begin
      ok = (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
    end
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core request/response handshake plus data-RAM port of the load/store unit.
// slave = LSU side, master = core/RAM side.
interface load_store_unit_if #(parameter int XLEN = 32);

  logic            req_valid;
  logic            req_ready;
  logic            req_store;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;
  logic [3:0]      mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/load_store_unit_align.sv
// load_align: picks the addressed byte/halfword lane out of a RAM word and
// sign- or zero-extends it according to the load funct3.
module load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      offset_i,
  output logic [XLEN-1:0] data_o
);

  logic [BYTE_W-1:0] byteSel;
  logic [HALF_W-1:0] halfSel;

  always_comb begin
    byteSel = rdata_i[int'(offset_i) * BYTE_W +: BYTE_W];
    halfSel = rdata_i[int'(offset_i[1]) * HALF_W +: HALF_W];
    data_o  = '0;
    case (funct3_i)
      LB:      data_o = {{(XLEN-BYTE_W){byteSel[BYTE_W-1]}}, byteSel};
      LBU:     data_o = {{(XLEN-BYTE_W){1'b0}}, byteSel};
      LH:      data_o = {{(XLEN-HALF_W){halfSel[HALF_W-1]}}, halfSel};
      LHU:     data_o = {{(XLEN-HALF_W){1'b0}}, halfSel};
      LW:      data_o = rdata_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: single-cycle RAM access with a 1-deep response stage.
// Define LSU_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus
);

  lsu_state_e      state_q, state_d;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic            err_q;
  logic            store_q;
  logic [XLEN-1:0] holdData_q;
  logic            holdErr_q;

  logic            accept;
  logic            legal;
  logic            misalign;
  logic            errNow;
  logic [1:0]      offEff;
  logic [XLEN-1:0] fmtData;
  logic [XLEN-1:0] respData;

  // Decode the incoming access; funct3[1:0] encodes size for every legal op.
  always_comb begin
    legal    = f3_legal(bus.req_store, bus.req_funct3);
    misalign = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
               ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_TRAP_EN
    errNow = !legal || misalign;
    offEff = bus.req_addr[1:0];
`else
    errNow = !legal;
    offEff = bus.req_addr[1:0];
    if (bus.req_funct3[1:0] == 2'b01) offEff = {bus.req_addr[1], 1'b0};
    else if (bus.req_funct3[1:0] == 2'b10) offEff = 2'b00;
`endif
  end

  assign accept        = bus.req_valid && bus.req_ready;
  assign bus.req_ready = (state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready);
  assign bus.mem_addr  = bus.req_addr;

  always_comb begin
    bus.mem_we    = 4'b0000;
    bus.mem_wdata = bus.req_wdata;
    case (bus.req_funct3[1:0])
      2'b00:   bus.mem_wdata = {NUM_LANES{bus.req_wdata[BYTE_W-1:0]}};
      2'b01:   bus.mem_wdata = {(NUM_LANES/2){bus.req_wdata[HALF_W-1:0]}};
      default: bus.mem_wdata = bus.req_wdata;
    endcase
    if (!rst && accept && bus.req_store && !errNow) begin
      case (bus.req_funct3[1:0])
        2'b00:   bus.mem_we = 4'b0001 << offEff;
        2'b01:   bus.mem_we = 4'b0011 << offEff;
        default: bus.mem_we = 4'b1111;
      endcase
    end
  end

  load_align #(.XLEN(XLEN)) u_align (
    .rdata_i  (bus.mem_rdata),
    .funct3_i (f3_q),
    .offset_i (off_q),
    .data_o   (fmtData)
  );

  assign respData = (err_q || store_q) ? '0 : fmtData;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = RESP;
      RESP: begin
        if (!bus.rsp_ready) state_d = HOLD;
        else if (accept)    state_d = RESP;
        else                state_d = IDLE;
      end
      HOLD: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.rsp_valid = (state_q != IDLE);
    bus.rsp_rdata = '0;
    bus.rsp_err   = 1'b0;
    if (state_q == RESP) begin
      bus.rsp_rdata = respData;
      bus.rsp_err   = err_q;
    end else if (state_q == HOLD) begin
      bus.rsp_rdata = holdData_q;
      bus.rsp_err   = holdErr_q;
    end
  end

  // The RAM only presents the read word for one cycle, so a stalled
  // response has to be frozen here before leaving RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      f3_q       <= '0;
      off_q      <= '0;
      err_q      <= 1'b0;
      store_q    <= 1'b0;
      holdData_q <= '0;
      holdErr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        f3_q    <= bus.req_funct3;
        off_q   <= offEff;
        err_q   <= errNow;
        store_q <= bus.req_store;
      end
      if ((state_q == RESP) && !bus.rsp_ready) begin
        holdData_q <= respData;
        holdErr_q  <= err_q;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a registered-read RAM model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk;
  logic rst;
  logic ramClr;
  int   checks;
  int   errors;
  logic [31:0] ram [0:15];

  load_store_unit_if #(.XLEN(32)) bus ();

  load_store_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ramClr) begin
      for (int i = 0; i < 16; i++) ram[i] <= 32'h0;
      bus.mem_rdata <= 32'h0;
    end else begin
      for (int l = 0; l < 4; l++)
        if (bus.mem_we[l]) ram[bus.mem_addr[5:2]][8*l +: 8] <= bus.mem_wdata[8*l +: 8];
      bus.mem_rdata <= ram[bus.mem_addr[5:2]];
    end
  end

  task automatic applyStimulus(input logic v, input logic st, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd, input logic rr);
    bus.req_valid  = v;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.rsp_ready  = rr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    ramClr = 1'b1;
    applyStimulus(1, 1, SW, 32'h10, 32'hDEADBEEF, 1);
    @(negedge clk);
    applyStimulus(1, 1, SW, 32'h10, 32'hDEADBEEF, 1);
    checkOutput("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
    checkOutput("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    checkOutput("rst_rsp_err", {31'b0, bus.rsp_err}, 32'h0);
    checkOutput("rst_mem_we", {28'b0, bus.mem_we}, 32'h0);
    @(negedge clk);
    rst    = 1'b0;
    ramClr = 1'b0;

    applyStimulus(1, 1, SW, 32'h10, 32'hDEADBEEF, 1);
    checkOutput("sw_we", {28'b0, bus.mem_we}, 32'hF);
    checkOutput("sw_wdata", bus.mem_wdata, 32'hDEADBEEF);
    checkOutput("idle_req_ready", {31'b0, bus.req_ready}, 32'h1);
    @(negedge clk);

    applyStimulus(1, 0, LW, 32'h10, 32'h0, 1);
    checkOutput("sw_rsp_valid", {31'b0, bus.rsp_valid}, 32'h1);
    checkOutput("sw_rsp_rdata", bus.rsp_rdata, 32'h0);
    checkOutput("sw_rsp_err", {31'b0, bus.rsp_err}, 32'h0);
    checkOutput("resp_req_ready", {31'b0, bus.req_ready}, 32'h1);
    checkOutput("lw_we", {28'b0, bus.mem_we}, 32'h0);
    @(negedge clk);

    applyStimulus(1, 1, SB, 32'h13, 32'h00000080, 1);
    checkOutput("lw_rdata", bus.rsp_rdata, 32'hDEADBEEF);
    checkOutput("lw_rsp_valid", {31'b0, bus.rsp_valid}, 32'h1);
    checkOutput("sb_we", {28'b0, bus.mem_we}, 32'h8);
    checkOutput("sb_wdata", bus.mem_wdata, 32'h80808080);
    @(negedge clk);

    applyStimulus(1, 0, LB, 32'h13, 32'h0, 1);
    checkOutput("sb_rsp_rdata", bus.rsp_rdata, 32'h0);
    @(negedge clk);

    applyStimulus(1, 0, LBU, 32'h13, 32'h0, 1);
    checkOutput("lb_rdata", bus.rsp_rdata, 32'hFFFFFF80);
    @(negedge clk);

    applyStimulus(1, 1, SH, 32'h12, 32'h00008001, 1);
    checkOutput("lbu_rdata", bus.rsp_rdata, 32'h00000080);
    checkOutput("sh_we", {28'b0, bus.mem_we}, 32'hC);
    checkOutput("sh_wdata", bus.mem_wdata, 32'h80018001);
    @(negedge clk);

    applyStimulus(1, 0, LH, 32'h12, 32'h0, 1);
    checkOutput("sh_rsp_rdata", bus.rsp_rdata, 32'h0);
    @(negedge clk);

    applyStimulus(1, 0, LHU, 32'h12, 32'h0, 1);
    checkOutput("lh_rdata", bus.rsp_rdata, 32'hFFFF8001);
    @(negedge clk);

    applyStimulus(0, 0, LW, 32'h0, 32'h0, 1);
    checkOutput("lhu_rdata", bus.rsp_rdata, 32'h00008001);
    @(negedge clk);

    applyStimulus(1, 0, LW, 32'h10, 32'h0, 0);
    checkOutput("drain_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
    checkOutput("pre_hold_ready", {31'b0, bus.req_ready}, 32'h1);
    @(negedge clk);

    applyStimulus(1, 1, SW, 32'h14, 32'h12345678, 0);
    checkOutput("stall_rdata", bus.rsp_rdata, 32'h8001BEEF);
    checkOutput("stall_req_ready", {31'b0, bus.req_ready}, 32'h0);
    checkOutput("stall_we", {28'b0, bus.mem_we}, 32'h0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 1, SW, 32'h14, 32'h12345678, 0);
      checkOutput("hold_rsp_valid", {31'b0, bus.rsp_valid}, 32'h1);
      checkOutput("hold_rdata", bus.rsp_rdata, 32'h8001BEEF);
      checkOutput("hold_req_ready", {31'b0, bus.req_ready}, 32'h0);
      checkOutput("hold_we", {28'b0, bus.mem_we}, 32'h0);
      @(negedge clk);
    end
    applyStimulus(0, 0, LW, 32'h0, 32'h0, 1);
    checkOutput("hold_release_rdata", bus.rsp_rdata, 32'h8001BEEF);
    checkOutput("hold_release_valid", {31'b0, bus.rsp_valid}, 32'h1);
    @(negedge clk);

    applyStimulus(1, 0, LW, 32'h11, 32'h0, 1);
    checkOutput("single_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
    @(negedge clk);

    applyStimulus(1, 1, 3'b111, 32'h10, 32'hFFFFFFFF, 1);
`ifdef LSU_MISALIGN_TRAP_EN
    checkOutput("mis_lw_err", {31'b0, bus.rsp_err}, 32'h1);
    checkOutput("mis_lw_rdata", bus.rsp_rdata, 32'h0);
`else
    checkOutput("mis_lw_err", {31'b0, bus.rsp_err}, 32'h0);
    checkOutput("mis_lw_rdata", bus.rsp_rdata, 32'h8001BEEF);
`endif
    checkOutput("ill_st_we", {28'b0, bus.mem_we}, 32'h0);
    @(negedge clk);

    applyStimulus(1, 0, 3'b011, 32'h10, 32'h0, 1);
    checkOutput("ill_st_err", {31'b0, bus.rsp_err}, 32'h1);
    checkOutput("ill_st_rdata", bus.rsp_rdata, 32'h0);
    @(negedge clk);

    applyStimulus(1, 0, LW, 32'h10, 32'h0, 1);
    checkOutput("ill_ld_err", {31'b0, bus.rsp_err}, 32'h1);
    checkOutput("ill_ld_rdata", bus.rsp_rdata, 32'h0);
    @(negedge clk);

    applyStimulus(1, 0, LW, 32'h10, 32'h0, 0);
    checkOutput("post_ill_rdata", bus.rsp_rdata, 32'h8001BEEF);
    checkOutput("post_ill_err", {31'b0, bus.rsp_err}, 32'h0);
    @(negedge clk);

    applyStimulus(0, 0, LW, 32'h0, 32'h0, 0);
    @(negedge clk);
    applyStimulus(1, 1, SW, 32'h10, 32'hAAAAAAAA, 0);
    checkOutput("prerst_hold_valid", {31'b0, bus.rsp_valid}, 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("rst_hold_valid", {31'b0, bus.rsp_valid}, 32'h0);
    checkOutput("rst_hold_we", {28'b0, bus.mem_we}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 0, LW, 32'h0, 32'h0, 1);
    checkOutput("postrst_valid", {31'b0, bus.rsp_valid}, 32'h0);
    checkOutput("postrst_ready", {31'b0, bus.req_ready}, 32'h1);
    @(negedge clk);

    applyStimulus(1, 0, LW, 32'h10, 32'h0, 1);
    checkOutput("postrst_still_idle", {31'b0, bus.rsp_valid}, 32'h0);
    @(negedge clk);
    applyStimulus(0, 0, LW, 32'h0, 32'h0, 1);
    checkOutput("postrst_ram_intact", bus.rsp_rdata, 32'h8001BEEF);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
